// File: rtl/ppu_timing_ctrl.sv
// rtl/ppu_timing_ctrl.sv - PPU dot/line sequencer with LCDC/STAT/LY/LYC registers and interrupts
// Optional DRAW_HANDSHAKE_EN: DRAW length set by draw_done, forced to end at dot 369.
module ppu_timing_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  MMIO_DATA_in,
  input  logic        draw_done,
  output logic [1:0]  PPU_MODE,
  output logic [7:0]  LY,
  output logic [8:0]  DOT,
  output logic [7:0]  LCDC,
  output logic        line_start,
  output logic        IRQ_V_BLANK,
  output logic        IRQ_LCDC,
  output logic        OAM_CPU_BLOCK,
  output logic        VRAM_CPU_BLOCK
);

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_DRAW   = 2'd3
  } mode_e;

  localparam logic [15:0] ADDR_LCDC = 16'hFF40;
  localparam logic [15:0] ADDR_STAT = 16'hFF41;
  localparam logic [15:0] ADDR_LY   = 16'hFF44;
  localparam logic [15:0] ADDR_LYC  = 16'hFF45;

  localparam logic [8:0] LAST_DOT   = 9'd455;
  localparam logic [8:0] DRAW_START = 9'd80;
  localparam logic [7:0] LAST_LINE  = 8'd153;
  localparam logic [7:0] VBL_LINE   = 8'd144;

  mode_e       mode_q, mode_d;
  logic [8:0]  dot_q, dot_d;
  logic [7:0]  ly_q, ly_d;
  logic [7:0]  lcdc_q, lcdc_d;
  logic [7:0]  lyc_q, lyc_d;
  logic [3:0]  stat_en_q, stat_en_d;
  logic        stat_prev_q, stat_prev_d;
  logic        irq_lcdc_q, irq_lcdc_d;
  logic        irq_vblank_q, irq_vblank_d;
  logic        line_start_q, line_start_d;
  logic        oam_block_q, oam_block_d;
  logic        vram_block_q, vram_block_d;

  logic        ly_eq_lyc;
  logic        stat_line;
  logic [7:0]  rd_data;

`ifndef DRAW_HANDSHAKE_EN
  logic unused_draw_done;
  assign unused_draw_done = draw_done;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= MODE_HBLANK;
      dot_q        <= 9'd0;
      ly_q         <= 8'd0;
      lcdc_q       <= 8'h00;
      lyc_q        <= 8'h00;
      stat_en_q    <= 4'h0;
      stat_prev_q  <= 1'b0;
      irq_lcdc_q   <= 1'b0;
      irq_vblank_q <= 1'b0;
      line_start_q <= 1'b0;
      oam_block_q  <= 1'b0;
      vram_block_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      dot_q        <= dot_d;
      ly_q         <= ly_d;
      lcdc_q       <= lcdc_d;
      lyc_q        <= lyc_d;
      stat_en_q    <= stat_en_d;
      stat_prev_q  <= stat_prev_d;
      irq_lcdc_q   <= irq_lcdc_d;
      irq_vblank_q <= irq_vblank_d;
      line_start_q <= line_start_d;
      oam_block_q  <= oam_block_d;
      vram_block_q <= vram_block_d;
    end
  end

  // STAT source evaluation uses only registered state, so it sees mode and enables together.
  always_comb begin
    ly_eq_lyc = (ly_q == lyc_q);
    stat_line = lcdc_q[7] & (
                  (stat_en_q[0] & (mode_q == MODE_HBLANK)) |
                  (stat_en_q[1] & (mode_q == MODE_VBLANK)) |
                  (stat_en_q[2] & (mode_q == MODE_SCAN))   |
                  (stat_en_q[3] & ly_eq_lyc));
  end

  always_comb begin
    lcdc_d    = lcdc_q;
    stat_en_d = stat_en_q;
    lyc_d     = lyc_q;
    if (WR) begin
      case (ADDR)
        ADDR_LCDC: lcdc_d    = MMIO_DATA_out;
        ADDR_STAT: stat_en_d = MMIO_DATA_out[6:3];
        ADDR_LYC:  lyc_d     = MMIO_DATA_out;
        default:   ;
      endcase
    end
  end

  // A disable write overrides any wrap; an enable write restarts at line 0, dot 0.
  always_comb begin
    dot_d  = 9'd0;
    ly_d   = 8'd0;
    mode_d = MODE_HBLANK;
    if (lcdc_d[7] && lcdc_q[7]) begin
      if (dot_q == LAST_DOT) begin
        dot_d = 9'd0;
        ly_d  = (ly_q == LAST_LINE) ? 8'd0 : ly_q + 8'd1;
      end else begin
        dot_d = dot_q + 9'd1;
        ly_d  = ly_q;
      end

      if (ly_d >= VBL_LINE) begin
        mode_d = MODE_VBLANK;
      end else if (dot_d < DRAW_START) begin
        mode_d = MODE_SCAN;
      end else if (dot_d == DRAW_START) begin
        mode_d = MODE_DRAW;
      end else begin
`ifdef DRAW_HANDSHAKE_EN
        if ((mode_q == MODE_DRAW) && !draw_done && (dot_d < 9'd369)) begin
          mode_d = MODE_DRAW;
        end else begin
          mode_d = MODE_HBLANK;
        end
`else
        if (dot_d < 9'd252) begin
          mode_d = MODE_DRAW;
        end else begin
          mode_d = MODE_HBLANK;
        end
`endif
      end
    end else if (lcdc_d[7]) begin
      mode_d = MODE_SCAN;
    end
  end

  always_comb begin
    line_start_d = lcdc_d[7] && (dot_d == 9'd0) && (ly_d < VBL_LINE);
    oam_block_d  = (mode_d == MODE_SCAN) || (mode_d == MODE_DRAW);
    vram_block_d = (mode_d == MODE_DRAW);
    stat_prev_d  = stat_line;
    irq_lcdc_d   = lcdc_d[7] & stat_line & ~stat_prev_q;
    irq_vblank_d = lcdc_d[7] & (ly_q == VBL_LINE) & (dot_q == 9'd0);
  end

  always_comb begin
    rd_data = 8'hFF;
    if (RD) begin
      case (ADDR)
        ADDR_LCDC: rd_data = lcdc_q;
        ADDR_STAT: rd_data = {1'b1, stat_en_q, ly_eq_lyc, mode_q};
        ADDR_LY:   rd_data = ly_q;
        ADDR_LYC:  rd_data = lyc_q;
        default:   rd_data = 8'hFF;
      endcase
    end
  end

  assign MMIO_DATA_in   = rd_data;
  assign PPU_MODE       = mode_q;
  assign LY             = ly_q;
  assign DOT            = dot_q;
  assign LCDC           = lcdc_q;
  assign line_start     = line_start_q;
  assign IRQ_V_BLANK    = irq_vblank_q;
  assign IRQ_LCDC       = irq_lcdc_q;
  assign OAM_CPU_BLOCK  = oam_block_q;
  assign VRAM_CPU_BLOCK = vram_block_q;

endmodule

// File: tb/tb_ppu_timing_ctrl.sv
// tb/tb_ppu_timing_ctrl.sv - self-checking bench for ppu_timing_ctrl
// Frame model is kept as "cycles since LCD enable"; dot/line/mode are derived arithmetically.
`timescale 1ns/1ps
module tb_ppu_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic        WR = 1'b0;
  logic        RD = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        draw_done = 1'b0;
  logic [7:0]  MMIO_DATA_in;
  logic [1:0]  PPU_MODE;
  logic [7:0]  LY;
  logic [8:0]  DOT;
  logic [7:0]  LCDC;
  logic        line_start, IRQ_V_BLANK, IRQ_LCDC, OAM_CPU_BLOCK, VRAM_CPU_BLOCK;

  ppu_timing_ctrl dut (
    .clk(clk), .rst(rst_n), .ADDR(ADDR), .WR(WR), .RD(RD),
    .MMIO_DATA_out(wdata), .MMIO_DATA_in(MMIO_DATA_in), .draw_done(draw_done),
    .PPU_MODE(PPU_MODE), .LY(LY), .DOT(DOT), .LCDC(LCDC), .line_start(line_start),
    .IRQ_V_BLANK(IRQ_V_BLANK), .IRQ_LCDC(IRQ_LCDC),
    .OAM_CPU_BLOCK(OAM_CPU_BLOCK), .VRAM_CPU_BLOCK(VRAM_CPU_BLOCK)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int vb_cnt = 0;

  // Behavioural model state
  bit         m_on = 0;
  int         m_t = 0;
  logic [7:0] m_lcdc = 8'h00;
  logic [3:0] m_en = 4'h0;
  logic [7:0] m_lyc = 8'h00;
  bit         m_prev = 0;
  bit         m_irq_lcdc = 0;
  bit         m_irq_vb = 0;
  int         m_hs_end = 369;

  function automatic int mdot();
    return m_on ? (m_t % 456) : 0;
  endfunction

  function automatic int mly();
    return m_on ? (m_t / 456) : 0;
  endfunction

  function automatic int mmode();
    int d;
    int de;
    d = m_t % 456;
`ifdef DRAW_HANDSHAKE_EN
    de = m_hs_end;
`else
    de = 252;
`endif
    if (!m_on) return 0;
    if (m_t / 456 >= 144) return 1;
    if (d < 80) return 2;
    if (d < de) return 3;
    return 0;
  endfunction

  function automatic logic [7:0] mread();
    logic [1:0] mm;
    logic       eq;
    mm = 2'(mmode());
    eq = (8'(mly()) == m_lyc);
    if (!RD) return 8'hFF;
    case (ADDR)
      16'hFF40: return m_lcdc;
      16'hFF41: return {1'b1, m_en, eq, mm};
      16'hFF44: return 8'(mly());
      16'hFF45: return m_lyc;
      default:  return 8'hFF;
    endcase
  endfunction

  // Model update on every clock edge, asynchronous reset
  initial begin
    int d, l, md;
    bit line;
    logic [7:0] nl;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_on = 0; m_t = 0; m_lcdc = 8'h00; m_en = 4'h0; m_lyc = 8'h00;
        m_prev = 0; m_irq_lcdc = 0; m_irq_vb = 0; m_hs_end = 369;
      end else begin
        d = mdot(); l = mly(); md = mmode();
        line = m_on && ((m_en[0] && md == 0) || (m_en[1] && md == 1) ||
                        (m_en[2] && md == 2) || (m_en[3] && 8'(l) == m_lyc));
        if (draw_done && md == 3 && d + 1 < m_hs_end) m_hs_end = d + 1;
        nl = m_lcdc;
        if (WR) begin
          if (ADDR == 16'hFF40) nl = wdata;
          if (ADDR == 16'hFF41) m_en = wdata[6:3];
          if (ADDR == 16'hFF45) m_lyc = wdata;
        end
        m_irq_lcdc = nl[7] && line && !m_prev;
        m_prev = line;
        m_irq_vb = nl[7] && l == 144 && d == 0;
        if (nl[7] && m_on) m_t = (m_t + 1) % 70224;
        else m_t = 0;
        if (m_t % 456 == 0) m_hs_end = 369;
        m_on = nl[7];
        m_lcdc = nl;
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    int ed, el, em;
    bit els, eo, ev;
    logic [7:0] er;
    forever begin
      @(negedge clk);
      ed = mdot(); el = mly(); em = mmode();
      els = m_on && ed == 0 && el < 144;
      eo = (em == 2) || (em == 3);
      ev = (em == 3);
      er = mread();
      checks++;
      if (DOT !== 9'(ed) || LY !== 8'(el) || PPU_MODE !== 2'(em) || LCDC !== m_lcdc ||
          line_start !== els || OAM_CPU_BLOCK !== eo || VRAM_CPU_BLOCK !== ev ||
          IRQ_LCDC !== m_irq_lcdc || IRQ_V_BLANK !== m_irq_vb || MMIO_DATA_in !== er) begin
        errors++;
        $display("FAIL cycle_compare n=%0d dut(dot=%0d ly=%0d mode=%0d lcdc=%h ls=%b oam=%b vram=%b irql=%b irqv=%b rd=%h) exp(dot=%0d ly=%0d mode=%0d lcdc=%h ls=%b oam=%b vram=%b irql=%b irqv=%b rd=%h)",
                 n, DOT, LY, PPU_MODE, LCDC, line_start, OAM_CPU_BLOCK, VRAM_CPU_BLOCK, IRQ_LCDC, IRQ_V_BLANK, MMIO_DATA_in,
                 ed, el, em, m_lcdc, els, eo, ev, m_irq_lcdc, m_irq_vb, er);
      end
      if (IRQ_V_BLANK === 1'b1) vb_cnt++;
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic goto(input int target);
    while (n < target) tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    ADDR = a; wdata = d; WR = 1'b1;
    tick();
    WR = 1'b0; ADDR = 16'h0000; wdata = 8'h00;
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    ADDR = a; RD = 1'b1;
    #1;
    lit(name, MMIO_DATA_in, exp);
    RD = 1'b0; ADDR = 16'h0000;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    lit("reset_dot", DOT, 0);
    lit("reset_ly", LY, 0);
    lit("reset_mode", PPU_MODE, 0);
    lit("reset_rd", MMIO_DATA_in, 8'hFF);
    lit("reset_irqs", {IRQ_LCDC, IRQ_V_BLANK, line_start}, 0);
    rst_n = 1'b1;
    tick(); tick();
    lit("off_blocks", {OAM_CPU_BLOCK, VRAM_CPU_BLOCK}, 0);
    lit("off_lcdc", LCDC, 0);
    rd_check("off_stat", 16'hFF41, 8'h84);
    wr(16'hFF45, 8'h05);

    wr(16'hFF40, 8'h80);
    n = 0; vb_cnt = 0;
    lit("on_dot", DOT, 0);
    lit("on_ly", LY, 0);
    lit("on_mode_scan", PPU_MODE, 2);
    lit("on_line_start", line_start, 1);
    lit("on_oam_block", OAM_CPU_BLOCK, 1);
    goto(1);   lit("line_start_pulse_end", line_start, 0);
    goto(79);  lit("dot79_scan", PPU_MODE, 2);
    goto(80);  lit("dot80_draw", PPU_MODE, 3);
    lit("draw_blocks", {OAM_CPU_BLOCK, VRAM_CPU_BLOCK}, 2'b11);
    goto(100); rd_check("stat_in_draw", 16'hFF41, 8'h83);
    wr(16'hFF44, 8'h77);
    lit("ly_write_ignored", LY, 0);
    rd_check("ly_read", 16'hFF44, 8'h00);
    goto(251); lit("dot251_draw", PPU_MODE, 3);
    goto(252); lit("dot252_hblank", PPU_MODE, 0);
    lit("hblank_blocks", {OAM_CPU_BLOCK, VRAM_CPU_BLOCK}, 0);
    goto(455); lit("dot455", DOT, 455);
    goto(456); lit("ly1_at_456", LY, 1);
    lit("dot0_at_456", DOT, 0);

    goto(500); wr(16'hFF41, 8'h40);
    goto(2280); rd_check("stat_lyc_match", 16'hFF41, 8'hC6);
    lit("lyc_irq_not_yet", IRQ_LCDC, 0);
    goto(2281); lit("lyc_irq_pulse", IRQ_LCDC, 1);
    goto(2282); lit("lyc_irq_one_cycle", IRQ_LCDC, 0);
    goto(2380); wr(16'hFF41, 8'h48);
    goto(2533); lit("no_second_pulse_l5_hblank", IRQ_LCDC, 0);
    goto(2989); lit("mode0_pulse_l6", IRQ_LCDC, 1);
    goto(3000); wr(16'hFF41, 8'h00);

    goto(3647); wr(16'hFF41, 8'h20);
    lit("stat_wr_at_mode_change_n", IRQ_LCDC, 0);
    goto(3649); lit("stat_wr_at_mode_change_irq", IRQ_LCDC, 1);
    goto(3700); wr(16'hFF41, 8'h00);

    goto(4304); lit("dd_line_draw", PPU_MODE, 3);
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
`ifdef DRAW_HANDSHAKE_EN
    lit("dd_hblank_201", PPU_MODE, 0);
    goto(4560 + 368); lit("hs_draw_368", PPU_MODE, 3);
    goto(4560 + 369); lit("hs_forced_369", PPU_MODE, 0);
`else
    lit("dd_ignored_201", PPU_MODE, 3);
    goto(4560 + 251); lit("fixed_draw_251", PPU_MODE, 3);
    goto(4560 + 252); lit("fixed_hblank_252", PPU_MODE, 0);
`endif
    goto(5016); lit("line11_dot0", DOT, 0);
    lit("line11_ly", LY, 11);

    goto(65663); lit("ly143", LY, 143);
    goto(65664); lit("ly144", LY, 144);
    lit("vblank_mode", PPU_MODE, 1);
    lit("vb_irq_not_yet", IRQ_V_BLANK, 0);
    goto(65665); lit("vb_irq_pulse", IRQ_V_BLANK, 1);
    goto(65666); lit("vb_irq_one_cycle", IRQ_V_BLANK, 0);
    goto(70223); lit("ly153", LY, 153);
    lit("ly153_dot455", DOT, 455);
    goto(70224); lit("frame_wrap_ly", LY, 0);
    lit("frame_wrap_mode", PPU_MODE, 2);
    lit("frame_wrap_line_start", line_start, 1);
    lit("one_vblank_per_frame", vb_cnt, 1);

    goto(70224 + 4560 + 150); lit("pre_disable_draw", PPU_MODE, 3);
    wr(16'hFF40, 8'h00);
    lit("disable_ly", LY, 0);
    lit("disable_dot", DOT, 0);
    lit("disable_mode", PPU_MODE, 0);
    lit("disable_blocks", {OAM_CPU_BLOCK, VRAM_CPU_BLOCK}, 0);
    goto(n + 5); lit("off_dot_held", DOT, 0);

    wr(16'hFF40, 8'h91);
    n = 0;
    lit("reenable_mode", PPU_MODE, 2);
    lit("reenable_ly", LY, 0);
    lit("reenable_line_start", line_start, 1);
    lit("reenable_lcdc", LCDC, 8'h91);

    goto(300);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    lit("async_reset_dot", DOT, 0);
    lit("async_reset_mode", PPU_MODE, 0);
    lit("async_reset_lcdc", LCDC, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();
    lit("post_reset_no_irq", {IRQ_LCDC, IRQ_V_BLANK}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
